// File: rtl/rgb2ycbcr_core_scheduler.sv
`timescale 1ns/1ps
// rgb2ycbcr_core_scheduler
//
// Purpose: time-multiplexes one PIXEL_COUNT-pixel RGB block onto CORE_COUNT
// parallel rgb2ycbcr cores. A block is latched on a start/done 4-phase
// handshake, issued one slice of CORE_COUNT pixels per cycle, and the returned
// core results are collected bit-exact into the Y/Cb/Cr block registers.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   start                    level request, held until done is observed
//   r_all/g_all/b_all        block samples, pixel i at [i*INPUT_WIDTH +: INPUT_WIDTH]
//   core_r/core_g/core_b     slice presented to the cores, core k at [k*INPUT_WIDTH +: INPUT_WIDTH]
//   core_in_valid            slice on core_r/g/b is valid this cycle
//   core_y/core_cb/core_cr   core results for one slice (returned in issue order)
//   core_out_valid           core results valid
//   y_all/cb_all/cr_all      collected block results (registered)
//   busy                     high while issuing or draining
//   done                     high while the completed block is held
//   protocol_err             sticky error, cleared when the next start is accepted
module rgb2ycbcr_core_scheduler #(
    parameter int PIXEL_COUNT        = 64,
    parameter int CORE_COUNT         = 8,
    parameter int INPUT_WIDTH        = 8,
    parameter int FIXED_POINT_LENGTH = 32,
    parameter int TIMEOUT            = 64
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic [INPUT_WIDTH*PIXEL_COUNT-1:0]        r_all,
    input  logic [INPUT_WIDTH*PIXEL_COUNT-1:0]        g_all,
    input  logic [INPUT_WIDTH*PIXEL_COUNT-1:0]        b_all,
    output logic [INPUT_WIDTH*CORE_COUNT-1:0]         core_r,
    output logic [INPUT_WIDTH*CORE_COUNT-1:0]         core_g,
    output logic [INPUT_WIDTH*CORE_COUNT-1:0]         core_b,
    output logic                                     core_in_valid,
    input  logic [FIXED_POINT_LENGTH*CORE_COUNT-1:0]  core_y,
    input  logic [FIXED_POINT_LENGTH*CORE_COUNT-1:0]  core_cb,
    input  logic [FIXED_POINT_LENGTH*CORE_COUNT-1:0]  core_cr,
    input  logic                                     core_out_valid,
    output logic [FIXED_POINT_LENGTH*PIXEL_COUNT-1:0] y_all,
    output logic [FIXED_POINT_LENGTH*PIXEL_COUNT-1:0] cb_all,
    output logic [FIXED_POINT_LENGTH*PIXEL_COUNT-1:0] cr_all,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     protocol_err
);

    localparam int BEATS       = PIXEL_COUNT / CORE_COUNT;
    localparam int CNT_W       = $clog2(BEATS) + 1;
    localparam int TMR_W       = $clog2(TIMEOUT) + 1;
    localparam int IN_SLICE_W  = INPUT_WIDTH * CORE_COUNT;
    localparam int OUT_SLICE_W = FIXED_POINT_LENGTH * CORE_COUNT;
    localparam int IN_BLK_W    = INPUT_WIDTH * PIXEL_COUNT;
    localparam int OUT_BLK_W   = FIXED_POINT_LENGTH * PIXEL_COUNT;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] BEATS_C   = CNT_W'(BEATS);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [IN_BLK_W-1:0]  r_buf_q, r_buf_d;
    logic [IN_BLK_W-1:0]  g_buf_q, g_buf_d;
    logic [IN_BLK_W-1:0]  b_buf_q, b_buf_d;
    logic [OUT_BLK_W-1:0] y_q, y_d;
    logic [OUT_BLK_W-1:0] cb_q, cb_d;
    logic [OUT_BLK_W-1:0] cr_q, cr_d;
    logic [CNT_W-1:0]     issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]     wr_cnt_q, wr_cnt_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic                 perr_q, perr_d;

    // A result is only legitimate while a run is in flight and slices are
    // still outstanding; anything else is a stray and gets flagged.
    logic wr_accept;
    logic wr_last;
    logic drain_timeout;

    assign wr_accept     = core_out_valid && (state_q == S_ISSUE || state_q == S_DRAIN)
                           && (wr_cnt_q < BEATS_C);
    assign wr_last       = wr_accept && (wr_cnt_q == LAST_BEAT);
    assign drain_timeout = (state_q == S_DRAIN) && !core_out_valid && (timer_q == TMR_LAST);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ISSUE;
            S_ISSUE: if (issue_cnt_q == LAST_BEAT) state_d = S_DRAIN;
            S_DRAIN: if (drain_timeout) state_d = S_DONE;
            S_DONE:  if (!start) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // The final write completes the block even if issue is still running.
        if (wr_last) begin
            state_d = S_DONE;
        end
    end

    // Datapath and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf_q     <= '0;
            g_buf_q     <= '0;
            b_buf_q     <= '0;
            y_q         <= '0;
            cb_q        <= '0;
            cr_q        <= '0;
            issue_cnt_q <= '0;
            wr_cnt_q    <= '0;
            timer_q     <= '0;
            perr_q      <= 1'b0;
        end else begin
            r_buf_q     <= r_buf_d;
            g_buf_q     <= g_buf_d;
            b_buf_q     <= b_buf_d;
            y_q         <= y_d;
            cb_q        <= cb_d;
            cr_q        <= cr_d;
            issue_cnt_q <= issue_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            timer_q     <= timer_d;
            perr_q      <= perr_d;
        end
    end

    always_comb begin
        r_buf_d     = r_buf_q;
        g_buf_d     = g_buf_q;
        b_buf_d     = b_buf_q;
        y_d         = y_q;
        cb_d        = cb_q;
        cr_d        = cr_q;
        issue_cnt_d = issue_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        timer_d     = timer_q;
        perr_d      = perr_q;

        // Result collection runs independently of issue so that short core
        // latencies can return slices while later slices are still going out.
        if (core_out_valid) begin
            if (wr_accept) begin
                y_d[int'(wr_cnt_q)*OUT_SLICE_W +: OUT_SLICE_W]  = core_y;
                cb_d[int'(wr_cnt_q)*OUT_SLICE_W +: OUT_SLICE_W] = core_cb;
                cr_d[int'(wr_cnt_q)*OUT_SLICE_W +: OUT_SLICE_W] = core_cr;
                wr_cnt_d = wr_cnt_q + 1'b1;
            end else begin
                perr_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                // Accepting a new block wipes the previous results and error,
                // overriding a stray result arriving in the same cycle.
                if (start) begin
                    r_buf_d     = r_all;
                    g_buf_d     = g_all;
                    b_buf_d     = b_all;
                    y_d         = '0;
                    cb_d        = '0;
                    cr_d        = '0;
                    issue_cnt_d = '0;
                    wr_cnt_d    = '0;
                    timer_d     = '0;
                    perr_d      = 1'b0;
                end
            end
            S_ISSUE: begin
                issue_cnt_d = issue_cnt_q + 1'b1;
                timer_d     = '0;
            end
            S_DRAIN: begin
                // timer measures the gap since the last returned slice.
                if (core_out_valid) begin
                    timer_d = '0;
                end else if (timer_q == TMR_LAST) begin
                    perr_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Output logic
    always_comb begin
        core_in_valid = (state_q == S_ISSUE);
        busy          = (state_q == S_ISSUE) || (state_q == S_DRAIN);
        done          = (state_q == S_DONE);
        core_r        = '0;
        core_g        = '0;
        core_b        = '0;
        if (state_q == S_ISSUE) begin
            core_r = r_buf_q[int'(issue_cnt_q)*IN_SLICE_W +: IN_SLICE_W];
            core_g = g_buf_q[int'(issue_cnt_q)*IN_SLICE_W +: IN_SLICE_W];
            core_b = b_buf_q[int'(issue_cnt_q)*IN_SLICE_W +: IN_SLICE_W];
        end
    end

    assign y_all        = y_q;
    assign cb_all       = cb_q;
    assign cr_all       = cr_q;
    assign protocol_err = perr_q;

endmodule

// File: tb/tb_rgb2ycbcr_core_scheduler.sv
`timescale 1ns/1ps
// Testbench for rgb2ycbcr_core_scheduler: a behavioural core bank with
// configurable latency feeds the DUT, expected blocks are queued at start and
// a monitor compares them when done rises.
module tb_rgb2ycbcr_core_scheduler;

    localparam int PC    = 64;
    localparam int CC    = 8;
    localparam int IW    = 8;
    localparam int FW    = 32;
    localparam int TO    = 64;
    localparam int BEATS = PC / CC;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [IW*PC-1:0]  r_all, g_all, b_all;
    logic [IW*CC-1:0]  core_r, core_g, core_b;
    logic              core_in_valid;
    logic [FW*CC-1:0]  core_y, core_cb, core_cr;
    logic              core_out_valid;
    logic [FW*PC-1:0]  y_all, cb_all, cr_all;
    logic              busy, done, protocol_err;

    rgb2ycbcr_core_scheduler #(
        .PIXEL_COUNT(PC), .CORE_COUNT(CC), .INPUT_WIDTH(IW),
        .FIXED_POINT_LENGTH(FW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .r_all(r_all), .g_all(g_all), .b_all(b_all),
        .core_r(core_r), .core_g(core_g), .core_b(core_b),
        .core_in_valid(core_in_valid),
        .core_y(core_y), .core_cb(core_cb), .core_cr(core_cr),
        .core_out_valid(core_out_valid),
        .y_all(y_all), .cb_all(cb_all), .cr_all(cr_all),
        .busy(busy), .done(done), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // BT.601 full-range conversion in Q16.16; coefficients sum exactly so a
    // grey pixel maps to Y = v<<16, Cb = Cr = 128<<16.
    function automatic logic [3*FW-1:0] conv(input int r, input int g, input int b);
        int y, cb, cr;
        y  = 19595*r + 38470*g + 7471*b;
        cb = 8388608 - 11059*r - 21709*g + 32768*b;
        cr = 8388608 + 32768*r - 27439*g - 5329*b;
        return {y[31:0], cb[31:0], cr[31:0]};
    endfunction

    function automatic logic [IW*PC-1:0] rand_blk();
        logic [IW*PC-1:0] v;
        for (int i = 0; i < PC; i++) v[i*IW +: IW] = IW'($urandom);
        return v;
    endfunction

    // ---------------- core bank model ----------------
    typedef struct {
        int              due;
        logic [FW*CC-1:0] y, cb, cr;
    } core_item_t;

    core_item_t       cq[$];
    int               lat = 3;
    int               slice_limit = BEATS;
    int               accepted_cnt = 0;
    int               sl_idx = 0;
    int               iv_cnt = 0;
    bit               spur_req = 0;
    logic [IW*PC-1:0] cur_r = '0, cur_g = '0, cur_b = '0;

    initial begin
        core_item_t it;
        logic [3*FW-1:0] res;
        core_out_valid = 1'b0;
        core_y = '0; core_cb = '0; core_cr = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                cq.delete();
                core_out_valid = 1'b0;
            end else begin
                if (core_in_valid) begin
                    iv_cnt++;
                    if (sl_idx < BEATS) begin
                        check("slice_r", core_r, cur_r[sl_idx*IW*CC +: IW*CC]);
                        check("slice_g", core_g, cur_g[sl_idx*IW*CC +: IW*CC]);
                        check("slice_b", core_b, cur_b[sl_idx*IW*CC +: IW*CC]);
                    end
                    sl_idx++;
                    if (accepted_cnt < slice_limit) begin
                        for (int k = 0; k < CC; k++) begin
                            res = conv(int'(core_r[k*IW +: IW]), int'(core_g[k*IW +: IW]),
                                       int'(core_b[k*IW +: IW]));
                            it.y[k*FW +: FW]  = res[3*FW-1 -: FW];
                            it.cb[k*FW +: FW] = res[2*FW-1 -: FW];
                            it.cr[k*FW +: FW] = res[FW-1:0];
                        end
                        it.due = cyc + 1 + lat;
                        cq.push_back(it);
                        accepted_cnt++;
                    end
                end
                if (spur_req) begin
                    spur_req = 0;
                    core_out_valid = 1'b1;
                    for (int k = 0; k < CC; k++) begin
                        core_y[k*FW +: FW]  = $urandom;
                        core_cb[k*FW +: FW] = $urandom;
                        core_cr[k*FW +: FW] = $urandom;
                    end
                end else if (cq.size() > 0 && cq[0].due == cyc) begin
                    it = cq.pop_front();
                    core_out_valid = 1'b1;
                    core_y = it.y; core_cb = it.cb; core_cr = it.cr;
                end else begin
                    core_out_valid = 1'b0;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [IW*PC-1:0] r, g, b;
        int               start_cyc;
        int               exp_lat;
        bit               exp_perr;
        int               valid_pix;
    } exp_t;

    exp_t sb_q[$];
    logic done_prev = 1'b0;

    initial begin
        exp_t e;
        logic [3*FW-1:0] ex;
        int bad;
        forever begin
            @(negedge clk);
            if (done && !done_prev) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 required no completion");
                end else begin
                    e = sb_q.pop_front();
                    if (e.exp_lat >= 0) check("done_latency", cyc - e.start_cyc, e.exp_lat);
                    check("perr_at_done", protocol_err, e.exp_perr);
                    check("busy_at_done", busy, 0);
                    bad = 0;
                    for (int i = 0; i < PC; i++) begin
                        ex = '0;
                        if (i < e.valid_pix)
                            ex = conv(int'(e.r[i*IW +: IW]), int'(e.g[i*IW +: IW]), int'(e.b[i*IW +: IW]));
                        if (y_all[i*FW +: FW]  !== ex[3*FW-1 -: FW] ||
                            cb_all[i*FW +: FW] !== ex[2*FW-1 -: FW] ||
                            cr_all[i*FW +: FW] !== ex[FW-1:0])
                            bad++;
                    end
                    check("block_bad_pixels", bad, 0);
                end
            end
            done_prev = done;
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_block(input logic [IW*PC-1:0] r, input logic [IW*PC-1:0] g,
                             input logic [IW*PC-1:0] b, input int l, input int limit,
                             input int exp_lat, input bit exp_perr, input int vpix,
                             input int hold_after);
        exp_t e;
        int n;
        lat = l; slice_limit = limit;
        cur_r = r; cur_g = g; cur_b = b;
        r_all = r; g_all = g; b_all = b;
        sl_idx = 0; iv_cnt = 0; accepted_cnt = 0;
        e.r = r; e.g = g; e.b = b;
        e.start_cyc = cyc + 1;
        e.exp_lat = exp_lat; e.exp_perr = exp_perr; e.valid_pix = vpix;
        sb_q.push_back(e);
        start = 1'b1;
        @(negedge clk);
        check("busy_after_start", busy, 1);
        check("perr_cleared_on_start", protocol_err, 0);
        // Inputs changing after acceptance must not affect this block.
        r_all = rand_blk(); g_all = rand_blk(); b_all = rand_blk();
        n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", done, 1);
        for (int h = 0; h < hold_after; h++) begin
            @(negedge clk);
            check("done_held", done, 1);
            check("no_reissue", core_in_valid, 0);
        end
        start = 1'b0;
        @(negedge clk);
        check("done_dropped", done, 0);
        check("idle_not_busy", busy, 0);
        check("in_valid_beats", iv_cnt, BEATS);
    endtask

    initial begin
        logic [IW*PC-1:0] ramp, red, zero, blk;
        logic [FW*PC-1:0] y_snap;
        int bad, n, l;
        rst = 1'b0; start = 1'b0;
        r_all = '0; g_all = '0; b_all = '0;
        zero = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in_valid", core_in_valid, 0);
        check("rst_perr", protocol_err, 0);
        check("rst_y_zero", |y_all, 0);
        check("rst_core_r", core_r, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Ramp block, L=3, start held 5 cycles past done.
        for (int i = 0; i < PC; i++) ramp[i*IW +: IW] = IW'(i);
        run_block(ramp, ramp, ramp, 3, BEATS, BEATS + 3 + 1, 0, PC, 5);
        bad = 0;
        for (int i = 0; i < PC; i++) if (y_all[i*FW +: FW] !== 32'(i << 16)) bad++;
        check("ramp_y_is_i_shl16", bad, 0);

        // Back-to-back returns overlapping issue.
        run_block(rand_blk(), rand_blk(), rand_blk(), 1, BEATS, BEATS + 1 + 1, 0, PC, 0);

        // Cores stop after 5 slices: drain timeout.
        run_block(rand_blk(), rand_blk(), rand_blk(), 3, 5, -1, 1, 5 * CC, 0);

        // A few random blocks at random latencies.
        for (int t = 0; t < 3; t++) begin
            l = $urandom_range(1, 4);
            run_block(rand_blk(), rand_blk(), rand_blk(), l, BEATS, BEATS + l + 1, 0, PC, $urandom_range(0, 2));
        end

        // Reset in the middle of issue beat 4.
        blk = rand_blk();
        cur_r = blk; cur_g = blk; cur_b = blk;
        r_all = blk; g_all = blk; b_all = blk;
        sl_idx = 0; iv_cnt = 0; accepted_cnt = 0; lat = 3; slice_limit = BEATS;
        start = 1'b1;
        n = 0;
        while (!busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("midrun_busy", busy, 1);
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_in_valid", core_in_valid, 0);
        check("async_rst_core_r", core_r, 0);
        check("async_rst_done", done, 0);
        check("async_rst_perr", protocol_err, 0);
        check("async_rst_y_zero", |y_all, 0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        red = '0;
        for (int i = 0; i < PC; i++) red[i*IW +: IW] = 8'hFF;
        run_block(red, zero, zero, 3, BEATS, BEATS + 3 + 1, 0, PC, 0);

        // Stray result while idle.
        y_snap = y_all;
        spur_req = 1;
        repeat (3) @(negedge clk);
        check("stray_perr", protocol_err, 1);
        check("stray_y_unchanged", y_all == y_snap, 1);
        check("stray_no_done", done, 0);
        run_block(rand_blk(), rand_blk(), rand_blk(), 3, BEATS, BEATS + 3 + 1, 0, PC, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
